// File: rtl/tone_player.sv
// Square-wave note player: accepts a step when note_ready, plays max(len,1) beats then a silent gap; done pulses on IDLE re-entry.
// Holds off upstream (note_ready=0) while playing; TONE_PLAYER_PAUSE_EN adds a pause input that freezes play and blocks accepts.
module tone_player #(
  parameter int DIV_W       = 20,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int SONG_LEN    = 149
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TONE_PLAYER_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             note_valid,
  input  logic [DIV_W-1:0] note_half,
  input  logic [2:0]       note_len,
  output logic             note_ready,
  output logic             audio,
  output logic             busy,
  output logic             done,
  output logic [7:0]       step_idx
);

  localparam int DUR_W = $clog2(8 * BEAT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [DUR_W-1:0] BEAT     = DUR_W'(BEAT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0]       IDX_LAST = 8'(SONG_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_half;
  logic [2:0]       r_len;
  logic [DIV_W-1:0] r_tone_cnt;
  logic [DUR_W-1:0] r_dur_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_ready;
  logic             r_audio;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_idx;

  logic             w_pause;
  logic             w_accept;
  logic [3:0]       w_len_eff;
  logic [DUR_W-1:0] w_dur_last;
  logic             w_tone_wrap;
  logic             w_dur_end;

`ifdef TONE_PLAYER_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign note_ready = r_ready & ~w_pause;
  assign audio      = r_audio & ~w_pause;
  assign busy       = r_busy;
  assign done       = r_done;
  assign step_idx   = r_idx;

  assign w_accept    = note_valid & note_ready;
  assign w_len_eff   = (r_len == 3'd0) ? 4'd1 : {1'b0, r_len};
  // len_eff <= 8, and DUR_W holds 8*BEAT, so the product cannot wrap
  assign w_dur_last  = DUR_W'(w_len_eff) * BEAT - DUR_W'(1);
  assign w_tone_wrap = (r_tone_cnt == r_half - DIV_W'(1));
  assign w_dur_end   = (r_dur_cnt == w_dur_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_half     <= '0;
      r_len      <= '0;
      r_tone_cnt <= '0;
      r_dur_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_ready    <= 1'b1;
      r_audio    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= IDX_LAST;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_half     <= note_half;
            r_len      <= note_len;
            r_idx      <= (r_idx == IDX_LAST) ? 8'd0 : r_idx + 8'd1;
            r_tone_cnt <= '0;
            r_dur_cnt  <= '0;
            r_audio    <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (w_pause) begin
            r_audio <= 1'b0;
          end else begin
            if (r_half != '0) begin
              if (w_tone_wrap) begin
                r_tone_cnt <= '0;
                r_audio    <= ~r_audio;
              end else begin
                r_tone_cnt <= r_tone_cnt + DIV_W'(1);
              end
            end
            if (w_dur_end) begin
              r_audio   <= 1'b0;
              r_dur_cnt <= '0;
              if (GAP_CYCLES > 0) begin
                r_gap_cnt <= '0;
                r_state   <= S_GAP;
              end else begin
                r_busy  <= 1'b0;
                r_ready <= 1'b1;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_dur_cnt <= r_dur_cnt + DUR_W'(1);
            end
          end
        end
        S_GAP: begin
          if (!w_pause) begin
            if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt <= '0;
              r_busy    <= 1'b0;
              r_ready   <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
